// File: rtl/dcs_reply_arbiter.sv
// dcs_reply_arbiter
//   Round-robin arbiter sharing the single DCS reply FIFO write path among
//   NREQ reply sources. Each source posts into a one-deep holding slot; one
//   reply at a time is issued to the write FSM, whose busy window is tracked
//   through udp_reply_stored. Posts to an occupied slot are dropped.
//
//   Optional feature macro: DCS_ARB_STATS_EN builds per-requester 8-bit
//   saturating drop counters; otherwise drop_cnt is tied to zero.
//
// Ports
//   dcs_wr_clk        clock
//   reset             synchronous, active-high
//   req_update        per-requester one-cycle post pulse
//   req_reply         64-bit reply per requester, requester i at [64i+63:64i]
//   req_dst_port      16-bit UDP destination port per requester
//   req_src_port      16-bit UDP source port per requester
//   req_pending       holding slot occupied
//   req_drop          one-cycle pulse, post to that requester discarded
//   dcs_cmd_reply     reply to write FSM (held from grant to next grant)
//   dcs_cmd_update    one-cycle issue pulse to write FSM
//   dcs_udp_dst_port  destination port to write FSM
//   dcs_udp_src_port  source port to write FSM
//   udp_reply_stored  write FSM busy (its write enable)
//   grant_id          requester being issued or last issued
//   arb_timeout       sticky timeout flag, cleared by reset only
//   drop_cnt          per-requester drop counters, 8 bits each
module dcs_reply_arbiter #(
  parameter int NREQ     = 4,
  parameter int START_TO = 8,
  parameter int DONE_TO  = 63
) (
  input  logic                 dcs_wr_clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_update,
  input  logic [64*NREQ-1:0]   req_reply,
  input  logic [16*NREQ-1:0]   req_dst_port,
  input  logic [16*NREQ-1:0]   req_src_port,
  output logic [NREQ-1:0]      req_pending,
  output logic [NREQ-1:0]      req_drop,
  output logic [63:0]          dcs_cmd_reply,
  output logic                 dcs_cmd_update,
  output logic [15:0]          dcs_udp_dst_port,
  output logic [15:0]          dcs_udp_src_port,
  input  logic                 udp_reply_stored,
  output logic [2:0]           grant_id,
  output logic                 arb_timeout,
  output logic [8*NREQ-1:0]    drop_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    GAP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [5:0]      timer;
  logic [5:0]      timer_nxt;
  logic            set_timeout;

  logic [63:0]     slot_reply [NREQ];
  logic [15:0]     slot_dst   [NREQ];
  logic [15:0]     slot_src   [NREQ];
  logic [NREQ-1:0] pending;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   rr_pos;
  logic            grant_now;
  logic [NREQ-1:0] gnt_vec;

  // Round-robin pick: offsets are scanned from farthest (grant_id itself)
  // to nearest (grant_id+1), so the last hit is the highest-priority one.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_pos    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      rr_pos = IW'((32'(grant_id) + 32'(NREQ) - k) % 32'(NREQ));
      if (pending[rr_pos]) begin
        win_found = 1'b1;
        win_idx   = rr_pos;
      end
    end
  end

  assign grant_now = (state == IDLE) && win_found;

  always_comb begin
    gnt_vec = '0;
    if (grant_now) begin
      gnt_vec[win_idx] = 1'b1;
    end
  end

  // Holding slots. A post in the same cycle its slot is granted refills the
  // slot (set wins over clear) and is not counted as a drop.
  always_ff @(posedge dcs_wr_clk) begin
    if (reset) begin
      pending  <= '0;
      req_drop <= '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        slot_reply[i] <= '0;
        slot_dst[i]   <= '0;
        slot_src[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        req_drop[i] <= req_update[i] & pending[i] & ~gnt_vec[i];
        if (req_update[i] && (!pending[i] || gnt_vec[i])) begin
          pending[i]    <= 1'b1;
          slot_reply[i] <= req_reply[64*i +: 64];
          slot_dst[i]   <= req_dst_port[16*i +: 16];
          slot_src[i]   <= req_src_port[16*i +: 16];
        end else if (gnt_vec[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  assign req_pending = pending;

  always_ff @(posedge dcs_wr_clk) begin
    if (reset) begin
      state            <= IDLE;
      timer            <= '0;
      arb_timeout      <= 1'b0;
      grant_id         <= 3'(NREQ - 1);
      dcs_cmd_reply    <= '0;
      dcs_udp_dst_port <= '0;
      dcs_udp_src_port <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      if (set_timeout) begin
        arb_timeout <= 1'b1;
      end
      if (grant_now) begin
        grant_id         <= 3'(win_idx);
        dcs_cmd_reply    <= slot_reply[win_idx];
        dcs_udp_dst_port <= slot_dst[win_idx];
        dcs_udp_src_port <= slot_src[win_idx];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    set_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = WAIT_START;
        timer_nxt = '0;
      end
      WAIT_START: begin
        if (udp_reply_stored) begin
          state_nxt = WAIT_DONE;
          timer_nxt = '0;
        end else if (timer == 6'(START_TO)) begin
          set_timeout = 1'b1;
          state_nxt   = GAP;
        end else begin
          timer_nxt = (timer == '1) ? timer : timer + 6'd1;
        end
      end
      WAIT_DONE: begin
        if (!udp_reply_stored) begin
          state_nxt = GAP;
        end else if (timer == 6'(DONE_TO)) begin
          set_timeout = 1'b1;
          state_nxt   = GAP;
        end else begin
          timer_nxt = (timer == '1) ? timer : timer + 6'd1;
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign dcs_cmd_update = (state == ISSUE);

`ifdef DCS_ARB_STATS_EN
  logic [7:0] cnt [NREQ];

  always_ff @(posedge dcs_wr_clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (req_drop[i] && (cnt[i] != '1)) begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    drop_cnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      drop_cnt[8*i +: 8] = cnt[i];
    end
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_dcs_reply_arbiter.sv
// tb_dcs_reply_arbiter
//   Directed bench for dcs_reply_arbiter with a nominal write-FSM model:
//   udp_reply_stored rises 2 cycles after dcs_cmd_update and stays high
//   for 26 cycles. The model can be disabled to hold udp_reply_stored low.
module tb_dcs_reply_arbiter;

  localparam int NREQ = 4;

`ifdef DCS_ARB_STATS_EN
  localparam logic [7:0] EXP_DROP2 = 8'd1;
`else
  localparam logic [7:0] EXP_DROP2 = 8'd0;
`endif

  logic                dcs_wr_clk;
  logic                reset;
  logic [NREQ-1:0]     req_update;
  logic [64*NREQ-1:0]  req_reply;
  logic [16*NREQ-1:0]  req_dst_port;
  logic [16*NREQ-1:0]  req_src_port;
  logic [NREQ-1:0]     req_pending;
  logic [NREQ-1:0]     req_drop;
  logic [63:0]         dcs_cmd_reply;
  logic                dcs_cmd_update;
  logic [15:0]         dcs_udp_dst_port;
  logic [15:0]         dcs_udp_src_port;
  logic                udp_reply_stored;
  logic [2:0]          grant_id;
  logic                arb_timeout;
  logic [8*NREQ-1:0]   drop_cnt;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  logic model_en = 1'b1;
  int   mcnt     = 0;

  dcs_reply_arbiter #(
    .NREQ     (NREQ),
    .START_TO (8),
    .DONE_TO  (63)
  ) dut (
    .dcs_wr_clk       (dcs_wr_clk),
    .reset            (reset),
    .req_update       (req_update),
    .req_reply        (req_reply),
    .req_dst_port     (req_dst_port),
    .req_src_port     (req_src_port),
    .req_pending      (req_pending),
    .req_drop         (req_drop),
    .dcs_cmd_reply    (dcs_cmd_reply),
    .dcs_cmd_update   (dcs_cmd_update),
    .dcs_udp_dst_port (dcs_udp_dst_port),
    .dcs_udp_src_port (dcs_udp_src_port),
    .udp_reply_stored (udp_reply_stored),
    .grant_id         (grant_id),
    .arb_timeout      (arb_timeout),
    .drop_cnt         (drop_cnt)
  );

  initial dcs_wr_clk = 1'b0;
  always #5 dcs_wr_clk = ~dcs_wr_clk;

  // Write-FSM model: mcnt counts cycles since the update pulse.
  initial udp_reply_stored = 1'b0;
  always @(posedge dcs_wr_clk) begin
    if (reset || !model_en) begin
      mcnt             <= 0;
      udp_reply_stored <= 1'b0;
    end else if (dcs_cmd_update) begin
      mcnt             <= 1;
      udp_reply_stored <= 1'b0;
    end else if (mcnt != 0) begin
      udp_reply_stored <= (mcnt >= 1) && (mcnt <= 26);
      mcnt             <= (mcnt >= 27) ? 0 : mcnt + 1;
    end else begin
      udp_reply_stored <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge dcs_wr_clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic post(input int i, input logic [63:0] r, input logic [15:0] d, input logic [15:0] s);
    req_update[i]           = 1'b1;
    req_reply[64*i +: 64]   = r;
    req_dst_port[16*i +: 16] = d;
    req_src_port[16*i +: 16] = s;
  endtask

  task automatic do_reset();
    req_update = '0;
    reset      = 1'b1;
    tick();
    reset      = 1'b0;
  endtask

  task automatic wait_update(input string tag, input int budget, output int at);
    int n;
    n = 0;
    while (dcs_cmd_update !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 64'(dcs_cmd_update), 64'd1);
    at = cyc;
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'h1111_1111_1111_1111 * 64'(i + 1);
  endfunction

  initial begin
    int   at;
    int   prev;
    int   tpost;
    int   u;
    logic seen;

    req_update   = '0;
    req_reply    = '0;
    req_dst_port = '0;
    req_src_port = '0;
    reset        = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_pending",  64'(req_pending), 64'd0);
    chk("rst_drop",     64'(req_drop), 64'd0);
    chk("rst_update",   64'(dcs_cmd_update), 64'd0);
    chk("rst_timeout",  64'(arb_timeout), 64'd0);
    chk("rst_reply",    dcs_cmd_reply, 64'd0);
    chk("rst_dst",      64'(dcs_udp_dst_port), 64'd0);
    chk("rst_src",      64'(dcs_udp_src_port), 64'd0);
    chk("rst_grant",    64'(grant_id), 64'd3);
    chk("rst_dropcnt",  64'(drop_cnt), 64'd0);
    reset = 1'b0;
    tick();

    // Single post on requester 1
    post(1, 64'h0123456789ABCDEF, 16'h1000, 16'h1001);
    tick();
    req_update = '0;
    chk("single_pending", 64'(req_pending), 64'h2);
    chk("single_upd_early", 64'(dcs_cmd_update), 64'd0);
    tick();
    chk("single_update", 64'(dcs_cmd_update), 64'd1);
    chk("single_reply",  dcs_cmd_reply, 64'h0123456789ABCDEF);
    chk("single_dst",    64'(dcs_udp_dst_port), 64'h1000);
    chk("single_src",    64'(dcs_udp_src_port), 64'h1001);
    chk("single_grant",  64'(grant_id), 64'd1);
    chk("single_pend_clr", 64'(req_pending), 64'd0);
    tick();
    chk("single_pulse_end", 64'(dcs_cmd_update), 64'd0);
    repeat (30) tick();

    // Simultaneous posts on all requesters after reset
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      post(i, pat(i), 16'h2000 + 16'(i), 16'h3000 + 16'(i));
    end
    tpost = cyc;
    tick();
    req_update = '0;
    prev = 0;
    for (int i = 0; i < NREQ; i++) begin
      wait_update("all_wait", 40, at);
      if (i == 0) begin
        chk("all_first_lat", 64'(at - tpost), 64'd2);
        chk("all_pend_after", 64'(req_pending), 64'hE);
      end else begin
        chk("all_period", 64'(at - prev), 64'd31);
      end
      chk("all_grant", 64'(grant_id), 64'(i));
      chk("all_reply", dcs_cmd_reply, pat(i));
      chk("all_dst",   64'(dcs_udp_dst_port), 64'h2000 + 64'(i));
      chk("all_src",   64'(dcs_udp_src_port), 64'h3000 + 64'(i));
      prev = at;
      tick();
      chk("all_one_pulse", 64'(dcs_cmd_update), 64'd0);
    end
    repeat (30) tick();

    // Drop on requester 2 while its slot is pending
    do_reset();
    post(0, 64'hAAAA_0000_0000_0000, 16'h0A00, 16'h0A01);
    tick();
    req_update = '0;
    tick();
    chk("drop_issue0", 64'(dcs_cmd_update), 64'd1);
    u = cyc;
    tick();
    post(2, 64'hBBBB_0000_0000_0002, 16'h0B00, 16'h0B01);
    tick();
    req_update = '0;
    chk("drop_pend2", 64'(req_pending), 64'h4);
    chk("drop_none_first", 64'(req_drop), 64'd0);
    tick();
    post(2, 64'hCCCC_0000_0000_0002, 16'h0C00, 16'h0C01);
    tick();
    req_update = '0;
    chk("drop_pulse", 64'(req_drop), 64'h4);
    chk("drop_pend_kept", 64'(req_pending), 64'h4);
    tick();
    chk("drop_pulse_end", 64'(req_drop), 64'd0);
    chk("drop_cnt2", 64'(drop_cnt[23:16]), 64'(EXP_DROP2));
    wait_update("drop_wait", 40, at);
    chk("drop_issue_time", 64'(at - u), 64'd31);
    chk("drop_grant", 64'(grant_id), 64'd2);
    chk("drop_reply_orig", dcs_cmd_reply, 64'hBBBB_0000_0000_0002);
    chk("drop_dst_orig", 64'(dcs_udp_dst_port), 64'h0B00);
    repeat (32) tick();

    // Post on requester 0 during its own grant cycle
    do_reset();
    post(0, 64'hD1D1_D1D1_0000_0001, 16'h0D10, 16'h0D11);
    tick();
    post(0, 64'hD2D2_D2D2_0000_0002, 16'h0D20, 16'h0D21);
    tick();
    req_update = '0;
    chk("gc_update", 64'(dcs_cmd_update), 64'd1);
    chk("gc_reply1", dcs_cmd_reply, 64'hD1D1_D1D1_0000_0001);
    chk("gc_no_drop", 64'(req_drop), 64'd0);
    chk("gc_pending", 64'(req_pending), 64'h1);
    u = cyc;
    tick();
    wait_update("gc_wait", 40, at);
    chk("gc_period", 64'(at - u), 64'd31);
    chk("gc_grant", 64'(grant_id), 64'd0);
    chk("gc_reply2", dcs_cmd_reply, 64'hD2D2_D2D2_0000_0002);
    chk("gc_src2", 64'(dcs_udp_src_port), 64'h0D21);
    repeat (32) tick();

    // Start timeout: write FSM never responds
    model_en = 1'b0;
    do_reset();
    post(1, 64'hEEEE_0000_0000_0001, 16'h0E00, 16'h0E01);
    post(3, 64'hFFFF_0000_0000_0003, 16'h0F00, 16'h0F01);
    tick();
    req_update = '0;
    tick();
    chk("to_issue1", 64'(grant_id), 64'd1);
    chk("to_update1", 64'(dcs_cmd_update), 64'd1);
    u = cyc;
    repeat (9) tick();
    chk("to_not_yet", 64'(arb_timeout), 64'd0);
    tick();
    chk("to_set", 64'(arb_timeout), 64'd1);
    wait_update("to_wait", 20, at);
    chk("to_next_time", 64'(at - u), 64'd12);
    chk("to_grant3", 64'(grant_id), 64'd3);
    chk("to_reply3", dcs_cmd_reply, 64'hFFFF_0000_0000_0003);
    tick();
    chk("to_sticky", 64'(arb_timeout), 64'd1);
    repeat (12) tick();
    model_en = 1'b1;

    // Reset during WAIT_DONE with 3 pending slots
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      post(i, pat(i + 4), 16'h4000 + 16'(i), 16'h5000 + 16'(i));
    end
    tick();
    req_update = '0;
    tick();
    chk("mr_issue0", 64'(dcs_cmd_update), 64'd1);
    chk("mr_pending3", 64'(req_pending), 64'hE);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_pending", 64'(req_pending), 64'd0);
    chk("mr_update", 64'(dcs_cmd_update), 64'd0);
    chk("mr_reply", dcs_cmd_reply, 64'd0);
    chk("mr_dst", 64'(dcs_udp_dst_port), 64'd0);
    chk("mr_src", 64'(dcs_udp_src_port), 64'd0);
    chk("mr_grant", 64'(grant_id), 64'd3);
    chk("mr_timeout", 64'(arb_timeout), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen = seen | dcs_cmd_update;
    end
    chk("mr_no_update", 64'(seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
